// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module  : pc_gen
// Purpose : Fetch-address generator. It boots from a fixed vector and then
//           steps sequentially. Exception, ERET and branch redirects take
//           priority in that order, and a branch that stalls is held as a
//           pending target until fetch accepts it.
// Revision: 1.0 - initial release
// ============================================================================
module pc_gen #(
    parameter logic [31:0] PC_INITIAL = 32'hbfc00000,
    parameter logic [31:0] PC_EXC     = 32'hbfc00380,
    parameter int unsigned FETCH_W    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_ready,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        eret_valid,
    input  logic [31:0] epc,
    input  logic        exc_valid,
    output logic [31:0] pc_out,
    output logic        pc_valid,
    output logic [31:0] pc_plus_4,
    output logic        pc_adel,
    output logic        redirect_pending
);

    localparam logic [1:0]  c_BOOT = 2'd0;
    localparam logic [1:0]  c_RUN  = 2'd1;
    localparam logic [1:0]  c_HOLD = 2'd2;
    localparam logic [31:0] c_STEP = 32'(4 * FETCH_W);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_pend_tgt;
    logic [31:0] w_pend_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_BOOT;
            r_pc       <= PC_INITIAL;
            r_pend_tgt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_pend_tgt <= w_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_pend_nxt  = r_pend_tgt;
        case (r_state)
            c_BOOT: begin
                w_state_nxt = c_RUN;
                w_pc_nxt    = PC_INITIAL;
            end
            c_RUN, c_HOLD: begin
                if (exc_valid) begin
                    w_pc_nxt    = PC_EXC;
                    w_pend_nxt  = '0;
                    w_state_nxt = c_RUN;
                end else if (eret_valid) begin
                    w_pc_nxt    = epc;
                    w_pend_nxt  = '0;
                    w_state_nxt = c_RUN;
                end else if (br_valid) begin
                    // Newest branch always replaces an older stalled one
                    if (if_ready) begin
                        w_pc_nxt    = br_target;
                        w_state_nxt = c_RUN;
                    end else begin
                        w_state_nxt = c_HOLD;
                    end
                    if (!if_ready || r_state == c_HOLD) begin
                        w_pend_nxt = br_target;
                    end
                end else if (if_ready) begin
                    w_pc_nxt    = (r_state == c_HOLD) ? r_pend_tgt : r_pc + c_STEP;
                    w_state_nxt = c_RUN;
                end
            end
            default: begin
                w_state_nxt = c_BOOT;
                w_pc_nxt    = PC_INITIAL;
                w_pend_nxt  = '0;
            end
        endcase
    end

    assign pc_out           = r_pc;
    assign pc_valid         = (r_state != c_BOOT);
    assign pc_plus_4        = r_pc + 32'd4;
    assign pc_adel          = pc_valid && (r_pc[1:0] != 2'b00);
    assign redirect_pending = (r_state == c_HOLD);

endmodule
`default_nettype wire
